iob_timer_sched: RTL and testbench

//  Shares one iob_timer instance among N_REQ requesters: round-robin arbiter plus sequencer.

---
 rtl/iob_timer_sched.sv | 160 ++++++++++++++++
 tb/tb_iob_timer_sched.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iob_timer_sched.sv
// Round-robin scheduler sharing one iob_timer among N_REQ requesters; each grant becomes a
// STOP / HIGH / LOW / RESET access sequence. Optional wait timeout: TIMER_SCHED_TIMEOUT_EN.
module iob_timer_sched #(
    parameter int N_REQ       = 4,
    parameter int TIMEOUT_CYC = 16,
    localparam int ID_W       = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req,
    input  logic [2*N_REQ-1:0] op,
    output logic [N_REQ-1:0]   ack,
    output logic [ID_W-1:0]    grant_id,
    output logic [63:0]        sample,
    output logic               sample_vld,
    output logic               busy,
    output logic               err,
    output logic               t_valid,
    output logic [1:0]         t_address,
    output logic [31:0]        t_wdata,
    input  logic [31:0]        t_rdata,
    input  logic               t_ready
);

    localparam logic [1:0] ADDR_RESET = 2'd0;
    localparam logic [1:0] ADDR_STOP  = 2'd1;
    localparam logic [1:0] ADDR_HIGH  = 2'd2;
    localparam logic [1:0] ADDR_LOW   = 2'd3;

    localparam logic [1:0] OP_SAMPLE     = 2'd0;
    localparam logic [1:0] OP_SAMPLE_CLR = 2'd1;
    localparam logic [1:0] OP_CLEAR      = 2'd2;

    if (N_REQ < 1 || TIMEOUT_CYC < 1) begin : g_param_check
        $error("iob_timer_sched: N_REQ and TIMEOUT_CYC must be >= 1");
    end

    typedef enum logic [3:0] {
        IDLE, STOP, STOP_W, HI, HI_W, LO, LO_W, CLR, CLR_W, DONE
    } state_t;

    state_t          state, state_nxt;
    logic [ID_W-1:0] rr;
    logic [1:0]      op_q;
    logic            found;
    logic [ID_W-1:0] pick;
    logic [ID_W:0]   cand;
    logic [1:0]      op_pick;
    logic            timeout;
    logic            aborted;

    // First requester at or after the rotation pointer, wrapping around.
    always_comb begin
        found = 1'b0;
        pick  = rr;
        cand  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = {1'b0, rr} + (ID_W+1)'(i);
            if (cand >= (ID_W+1)'(N_REQ))
                cand = cand - (ID_W+1)'(N_REQ);
            if (!found && req[cand[ID_W-1:0]]) begin
                found = 1'b1;
                pick  = cand[ID_W-1:0];
            end
        end
        op_pick = op[{pick, 1'b0} +: 2];
        if (op_pick == 2'd3)
            op_pick = OP_SAMPLE;
    end

    // Timer bus: t_valid is a single-cycle request; the matching *_W state then waits,
    // with t_valid low, for the t_ready pulse that completes it (one access outstanding).
    always_comb begin
        state_nxt = state;
        t_valid   = 1'b0;
        t_address = 2'd0;
        t_wdata   = 32'd0;
        case (state)
            IDLE:   if (found) state_nxt = (op_pick == OP_CLEAR) ? CLR : STOP;
            STOP:   begin t_valid = 1'b1; t_address = ADDR_STOP; state_nxt = STOP_W; end
            STOP_W: if (t_ready) state_nxt = HI; else if (timeout) state_nxt = DONE;
            HI:     begin t_valid = 1'b1; t_address = ADDR_HIGH; state_nxt = HI_W; end
            HI_W:   if (t_ready) state_nxt = LO; else if (timeout) state_nxt = DONE;
            LO:     begin t_valid = 1'b1; t_address = ADDR_LOW; state_nxt = LO_W; end
            LO_W:   if (t_ready) state_nxt = (op_q == OP_SAMPLE_CLR) ? CLR : DONE;
                    else if (timeout) state_nxt = DONE;
            CLR:    begin
                        t_valid   = 1'b1;
                        t_address = ADDR_RESET;
                        t_wdata   = 32'd1;
                        state_nxt = CLR_W;
                    end
            CLR_W:  if (t_ready) state_nxt = DONE; else if (timeout) state_nxt = DONE;
            DONE:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_id <= '0;
            op_q     <= OP_SAMPLE;
            rr       <= '0;
            sample   <= 64'd0;
        end else begin
            if (state == IDLE && found) begin
                grant_id <= pick;
                op_q     <= op_pick;
            end
            if (state == HI_W && t_ready)
                sample[63:32] <= t_rdata;
            if (state == LO_W && t_ready)
                sample[31:0] <= t_rdata;
            if (state == DONE)
                rr <= (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + 1'b1;
        end
    end

`ifdef TIMER_SCHED_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] wait_cnt;
    logic             abort_q;
    logic             in_wait;

    assign in_wait = (state == STOP_W) || (state == HI_W) || (state == LO_W) || (state == CLR_W);
    assign timeout = in_wait && !t_ready && (wait_cnt == CNT_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
            abort_q  <= 1'b0;
        end else begin
            wait_cnt <= in_wait ? wait_cnt + 1'b1 : '0;
            if (timeout)
                abort_q <= 1'b1;
            else if (state == IDLE)
                abort_q <= 1'b0;
        end
    end

    assign aborted = abort_q;
    assign err     = (state == DONE) && abort_q;
`else
    assign timeout = 1'b0;
    assign aborted = 1'b0;
    assign err     = 1'b0;
`endif

    assign busy       = (state != IDLE);
    assign ack        = (state == DONE) ? (N_REQ'(1) << grant_id) : '0;
    assign sample_vld = (state == DONE) && (op_q != OP_CLEAR) && !aborted;

endmodule

// File: tb/tb_iob_timer_sched.sv
// Bench for iob_timer_sched: behavioural timer on the bus side, round-robin reference
// model and access scoreboard on the requester side.
module tb_iob_timer_sched;

  localparam int N  = 4;
  localparam int TO = 16;
  localparam logic [1:0] A_RESET = 2'd0;
  localparam logic [1:0] A_STOP  = 2'd1;
  localparam logic [1:0] A_HIGH  = 2'd2;
  localparam logic [1:0] A_LOW   = 2'd3;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req;
  logic [2*N-1:0] op;
  logic [N-1:0]  ack;
  logic [1:0]    grant_id;
  logic [63:0]   sample;
  logic          sample_vld, busy, err;
  logic          t_valid;
  logic [1:0]    t_address;
  logic [31:0]   t_wdata, t_rdata;
  logic          t_ready;

  int n_checks = 0;
  int n_pass   = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  iob_timer_sched #(.N_REQ(N), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .req(req), .op(op), .ack(ack), .grant_id(grant_id),
    .sample(sample), .sample_vld(sample_vld), .busy(busy), .err(err),
    .t_valid(t_valid), .t_address(t_address), .t_wdata(t_wdata),
    .t_rdata(t_rdata), .t_ready(t_ready)
  );

  // ---------------- timer model ----------------
  logic [63:0] tcnt, tlatch;
  logic        pend;
  int          pdly;
  logic [1:0]  paddr;
  logic [31:0] pwdata;
  logic        stall = 1'b0;
  logic        jitter = 1'b0;
  int          overlap_err = 0;
  logic [33:0] acc_q[$];

  always @(posedge clk or posedge rst) begin : timer_model
    int d;
    logic fire;
    logic [1:0] fa;
    logic [31:0] fw;
    if (rst) begin
      tcnt    <= 64'h0000_0a5c_0000_0000;
      tlatch  <= 64'd0;
      t_ready <= 1'b0;
      t_rdata <= 32'd0;
      pend    <= 1'b0;
      pdly    <= 0;
      paddr   <= 2'd0;
      pwdata  <= 32'd0;
    end else begin
      fire = 1'b0;
      fa = 2'd0;
      fw = 32'd0;
      tcnt    <= tcnt + 64'd1;
      t_ready <= 1'b0;
      t_rdata <= $urandom;
      if (t_valid) begin
        if (pend) overlap_err <= overlap_err + 1;
        acc_q.push_back({t_address, t_wdata});
        d = jitter ? $urandom_range(0, 2) : 0;
        if (d == 0 && !stall) begin
          fire = 1'b1; fa = t_address; fw = t_wdata; pend <= 1'b0;
        end else begin
          pend <= 1'b1; pdly <= d; paddr <= t_address; pwdata <= t_wdata;
        end
      end else if (pend && !stall) begin
        if (pdly <= 1) begin
          fire = 1'b1; fa = paddr; fw = pwdata; pend <= 1'b0;
        end else begin
          pdly <= pdly - 1;
        end
      end
      if (fire) begin
        t_ready <= 1'b1;
        case (fa)
          A_STOP:  tlatch <= tcnt;
          A_HIGH:  t_rdata <= tlatch[63:32];
          A_LOW:   t_rdata <= tlatch[31:0];
          default: if (fw == 32'd1) tcnt <= 64'd0;
        endcase
      end
    end
  end

  // ---------------- scoreboard / reference model ----------------
  logic [33:0] exp_q[$];
  int          rr_m = 0;
  logic [63:0] last_sample = 64'd0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
  endtask

  function automatic int rr_pick(input logic [N-1:0] m, input int p);
    for (int k = 0; k < N; k++)
      if (m[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  // Wait for an ack pulse; n counts negedges from the call.
  task automatic wait_ack(input int bound, output int n, output int gid);
    n = 0;
    gid = -1;
    do begin
      @(negedge clk);
      n++;
    end while (ack == '0 && n < bound);
    if (ack == '0) check("ack_seen", {63'd0, |ack}, 64'd1);
    else for (int i = 0; i < N; i++) if (ack[i]) gid = i;
  endtask

  task automatic verify_ack(input int id, input int opc);
    int o;
    o = (opc == 3) ? 0 : opc;
    check("ack_id", ack, 64'(1 << id));
    check("grant_id", grant_id, id);
    check("busy_ack", busy, 1);
    check("err_ack", err, 0);
    exp_q.delete();
    if (o != 2) begin
      exp_q.push_back({A_STOP, 32'd0});
      exp_q.push_back({A_HIGH, 32'd0});
      exp_q.push_back({A_LOW, 32'd0});
    end
    if (o != 0) exp_q.push_back({A_RESET, 32'd1});
    check("acc_cnt", acc_q.size(), exp_q.size());
    while (exp_q.size() > 0 && acc_q.size() > 0)
      check("acc", acc_q.pop_front(), exp_q.pop_front());
    acc_q.delete();
    if (o != 2) last_sample = tlatch;
    check("sample", sample, last_sample);
    check("sample_vld", sample_vld, (o != 2) ? 1 : 0);
    rr_m = (id + 1) % N;
  endtask

  // ---------------- driver tasks ----------------
  task automatic run_single(input int id, input int opc, input int exp_lat);
    int n, gid;
    op[2*id +: 2] = 2'(opc);
    req[id] = 1'b1;
    wait_ack(64, n, gid);
    req[id] = 1'b0;
    if (gid >= 0) begin
      check("latency", n, exp_lat);
      verify_ack(id, opc);
      @(negedge clk);
      check("ack_pulse", ack, 0);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    @(negedge clk);
    rst = 1'b0;
    acc_q.delete();
    rr_m = 0;
    last_sample = 64'd0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n, gid, exp_id, seen;
    int order[5];
    logic [N-1:0] pend_m;
    int op_m[N];
    order = '{0, 1, 2, 3, 0};
    rst = 1'b1;
    req = '0;
    op  = '0;
    repeat (3) @(negedge clk);
    check("rst_ack", ack, 0);
    check("rst_sample", sample, 0);
    check("rst_vld", sample_vld, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    check("rst_tvalid", t_valid, 0);
    check("rst_taddr", t_address, 0);
    check("rst_twdata", t_wdata, 0);
    check("rst_gid", grant_id, 0);
    rst = 1'b0;
    acc_q.delete();
    @(negedge clk);

    // All four requesting SAMPLE at once: strict rotation, 8 cycles apart.
    op  = '0;
    req = '1;
    for (int k = 0; k < 5; k++) begin
      wait_ack(64, n, gid);
      if (gid < 0) break;
      check("rr_lat", n, (k == 0) ? 7 : 8);
      check("rr_model", order[k], rr_pick(req, rr_m));
      verify_ack(order[k], 0);
    end
    req = '0;
    @(negedge clk);

    run_single(0, 0, 7);
    run_single(2, 1, 9);
    run_single(0, 0, 7);
    check("post_clr_small", {63'd0, sample < 64'd16}, 1);
    run_single(1, 2, 3);
    run_single(3, 3, 7);

    // Reset while waiting for the HIGH read.
    op[1:0] = 2'd0;
    req[0]  = 1'b1;
    repeat (4) @(negedge clk);
    check("mid_busy", busy, 1);
    rst = 1'b1;
    #1;
    check("abort_tvalid", t_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_ack", ack, 0);
    req[0] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    acc_q.delete();
    rr_m = 0;
    last_sample = 64'd0;
    check("abort_sample", sample, 0);
    run_single(0, 0, 7);

    // Randomized traffic with variable timer latency.
    jitter = 1'b1;
    pend_m = '0;
    for (int i = 0; i < N; i++) op_m[i] = 0;
    for (int t = 0; t < 60; t++) begin
      if (pend_m == '0) begin
        pend_m = N'($urandom_range(1, (1 << N) - 1));
        for (int i = 0; i < N; i++) if (pend_m[i]) op_m[i] = $urandom_range(0, 3);
      end
      for (int i = 0; i < N; i++) op[2*i +: 2] = 2'(op_m[i]);
      req = pend_m;
      wait_ack(300, n, gid);
      if (gid < 0) break;
      exp_id = rr_pick(pend_m, rr_m);
      verify_ack(exp_id, op_m[exp_id]);
      pend_m[exp_id] = 1'b0;
      for (int i = 0; i < N; i++)
        if (!pend_m[i] && $urandom_range(0, 2) == 0) begin
          pend_m[i] = 1'b1;
          op_m[i] = $urandom_range(0, 3);
        end
    end
    req = '0;
    jitter = 1'b0;
    repeat (4) @(negedge clk);

    // Timer never answers.
    stall = 1'b1;
    acc_q.delete();
    op[3:2] = 2'd0;
    req[1]  = 1'b1;
`ifdef TIMER_SCHED_TIMEOUT_EN
    wait_ack(100, n, gid);
    req[1] = 1'b0;
    if (gid >= 0) begin
      check("to_lat", n, 1 + TO + 1);
      check("to_ack", ack, 4'b0010);
      check("to_err", err, 1);
      check("to_vld", sample_vld, 0);
      check("to_sample", sample, last_sample);
      @(negedge clk);
      check("to_err_pulse", err, 0);
    end
    stall = 1'b0;
    do_reset();
`else
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (ack != '0 || err) seen = 1;
    end
    check("stuck_noack", seen, 0);
    check("stuck_busy", busy, 1);
    check("stuck_err", err, 0);
    check("stuck_tvalid", t_valid, 0);
    stall = 1'b0;
    do_reset();
`endif
    run_single(2, 0, 7);
    check("no_overlap", overlap_err, 0);

    // ---------------- final report ----------------
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
